// File: rtl/axi_config_pkg.sv
// Shared constants and types for the config-bus arbiter: latency/port limits
// and the layout of one read-tracking pipeline entry.
package axi_config_pkg;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 8;
  localparam int PORTS_MIN  = 2;
  localparam int PORTS_MAX  = 16;

  // Index field is sized for the largest legal port count so one entry type serves every build.
  localparam int PIPE_VLD_W = 1;
  localparam int PIPE_IDX_W = $clog2(PORTS_MAX);

  typedef struct packed {
    logic [PIPE_VLD_W-1:0] vld;
    logic [PIPE_IDX_W-1:0] idx;
  } rd_pipe_t;

  function automatic int idx_width(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/axi_config_rr_arb.sv
// Round-robin selector: first requesting port at or after the pointer,
// wrapping from PORTS-1 back to 0.
module axi_config_rr_arb #(
  parameter int PORTS = 2,
  parameter int IDX_W = 1
) (
  input  logic [PORTS-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  localparam logic [IDX_W:0] PORTS_W = (IDX_W+1)'(PORTS);

  logic [IDX_W:0] cand;

  // Scan from the farthest offset down so the nearest requester is the last writer.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    for (int i = PORTS-1; i >= 0; i--) begin
      cand = {1'b0, ptr_i} + (IDX_W+1)'(i);
      if (cand >= PORTS_W) cand = cand - PORTS_W;
      if (req_i[cand[IDX_W-1:0]]) begin
        gnt_idx_o   = cand[IDX_W-1:0];
        gnt_valid_o = 1'b1;
      end
    end
    if (gnt_valid_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/axi_config_arb.sv
// Round-robin arbiter sharing one register bus between PORTS requesters;
// issues registered commands and routes fixed-latency read data back.
module axi_config_arb
  import axi_config_pkg::*;
#(
  parameter int PORTS      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH/8,
  parameter int RD_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [PORTS-1:0]            s_req_valid,
  output logic [PORTS-1:0]            s_req_ready,
  input  logic [PORTS-1:0]            s_req_we,
  input  logic [PORTS*ADDR_WIDTH-1:0] s_req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0] s_req_wdata,
  input  logic [PORTS*STRB_WIDTH-1:0] s_req_wstrb,
  output logic [PORTS-1:0]            s_resp_valid,
  output logic [DATA_WIDTH-1:0]       s_resp_rdata,
  output logic                        m_wr,
  output logic                        m_rd,
  output logic [ADDR_WIDTH-1:0]       m_addr,
  output logic [DATA_WIDTH-1:0]       m_wdata,
  output logic [STRB_WIDTH-1:0]       m_wstrb,
  input  logic [DATA_WIDTH-1:0]       m_rdata
);

  localparam int IDX_W = idx_width(PORTS);

  if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_rd_latency
    $error("axi_config_arb: RD_LATENCY=%0d outside %0d..%0d", RD_LATENCY, RD_LAT_MIN, RD_LAT_MAX);
  end
  if (PORTS < PORTS_MIN || PORTS > PORTS_MAX) begin : g_bad_ports
    $error("axi_config_arb: PORTS=%0d outside %0d..%0d", PORTS, PORTS_MIN, PORTS_MAX);
  end

  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [PORTS-1:0]      req_gated;
  logic [PORTS-1:0]      gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic                  m_wr_q, m_rd_q, m_wr_d, m_rd_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0] m_wdata_q, m_wdata_d;
  logic [STRB_WIDTH-1:0] m_wstrb_q, m_wstrb_d;
  logic [PIPE_IDX_W-1:0] m_idx_q, m_idx_d;
  rd_pipe_t              pipe_q [RD_LATENCY];

  // Nothing may be granted while reset is held, even with requests pending.
  assign req_gated = s_req_valid & {PORTS{rst_n}};

  axi_config_rr_arb #(
    .PORTS (PORTS),
    .IDX_W (IDX_W)
  ) u_rr_arb (
    .req_i       (req_gated),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_vld)
  );

  assign s_req_ready = gnt;

  always_comb begin
    ptr_d     = ptr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    m_idx_d   = m_idx_q;
    m_wr_d    = 1'b0;
    m_rd_d    = 1'b0;
    if (gnt_vld) begin
      ptr_d     = (gnt_idx == IDX_W'(PORTS-1)) ? '0 : gnt_idx + 1'b1;
      m_addr_d  = s_req_addr[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
      m_wdata_d = s_req_wdata[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
      m_wstrb_d = s_req_wstrb[gnt_idx*STRB_WIDTH +: STRB_WIDTH];
      m_idx_d   = PIPE_IDX_W'(gnt_idx);
      m_wr_d    = s_req_we[gnt_idx];
      m_rd_d    = ~s_req_we[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      m_wr_q    <= 1'b0;
      m_rd_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
      m_idx_q   <= '0;
      for (int i = 0; i < RD_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      ptr_q     <= ptr_d;
      m_wr_q    <= m_wr_d;
      m_rd_q    <= m_rd_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
      m_idx_q   <= m_idx_d;
      // Entry enters while m_rd is on the bus, so it exits RD_LATENCY cycles after the read strobe.
      pipe_q[0] <= '{vld: m_rd_q, idx: m_idx_q};
      for (int i = 1; i < RD_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign m_wr    = m_wr_q;
  assign m_rd    = m_rd_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

  always_comb begin
    s_resp_valid = '0;
    for (int p = 0; p < PORTS; p++) begin
      s_resp_valid[p] = pipe_q[RD_LATENCY-1].vld[0] &&
                        (pipe_q[RD_LATENCY-1].idx == PIPE_IDX_W'(p));
    end
  end

  assign s_resp_rdata = m_rdata;

endmodule

// File: tb/tb_axi_config_arb.sv
// Scoreboard bench for axi_config_arb: a 2-port/latency-2 instance for the
// data path and reset, and a 4-port/latency-1 instance for pointer wrap.
module tb_axi_config_arb;

  typedef struct {
    int          cyc;
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  typedef struct {
    int          cyc;
    logic [1:0]  vld;
    logic [31:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 2-port instance
  logic [1:0]  v2, r2, we2, rv2;
  logic [63:0] addr2, wdata2;
  logic [7:0]  wstrb2;
  logic [31:0] rdata2, maddr2, mwdata2, mrdata2;
  logic [3:0]  mwstrb2;
  logic        mwr2, mrd2;

  axi_config_arb #(.PORTS(2), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .s_req_valid(v2), .s_req_ready(r2), .s_req_we(we2),
    .s_req_addr(addr2), .s_req_wdata(wdata2), .s_req_wstrb(wstrb2),
    .s_resp_valid(rv2), .s_resp_rdata(rdata2),
    .m_wr(mwr2), .m_rd(mrd2), .m_addr(maddr2), .m_wdata(mwdata2), .m_wstrb(mwstrb2),
    .m_rdata(mrdata2)
  );

  // 4-port instance
  logic [3:0]   v4, r4, we4, rv4;
  logic [127:0] addr4, wdata4;
  logic [15:0]  wstrb4;
  logic [31:0]  rdata4, maddr4, mwdata4;
  logic [3:0]   mwstrb4;
  logic         mwr4, mrd4;

  axi_config_arb #(.PORTS(4), .RD_LATENCY(1)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .s_req_valid(v4), .s_req_ready(r4), .s_req_we(we4),
    .s_req_addr(addr4), .s_req_wdata(wdata4), .s_req_wstrb(wstrb4),
    .s_resp_valid(rv4), .s_resp_rdata(rdata4),
    .m_wr(mwr4), .m_rd(mrd4), .m_addr(maddr4), .m_wdata(mwdata4), .m_wstrb(mwstrb4),
    .m_rdata(32'h0)
  );

  // Register model: data for the address that was on the bus two cycles earlier.
  logic [31:0] sh0, sh1;
  always @(posedge clk) begin
    sh0 <= maddr2;
    sh1 <= sh0;
  end
  always_comb begin
    case (sh1)
      32'h20:  mrdata2 = 32'h12345678;
      32'h24:  mrdata2 = 32'hCAFEBABE;
      32'h30:  mrdata2 = 32'hDEADBEEF;
      default: mrdata2 = 32'h0;
    endcase
  end

  logic [1:0] exp_gnt2[$];
  logic [3:0] exp_gnt4[$];
  cmd_t       exp_cmd[$];
  resp_t      exp_resp[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cmd_t  c;
    resp_t r;
    if (rst_n && r2 != 2'b00) begin
      if (exp_gnt2.size() == 0) check("gnt2_unexpected", 64'(r2), 64'(0));
      else check("gnt2", 64'(r2), 64'(exp_gnt2.pop_front()));
    end
    if (rst_n && r4 != 4'b0000) begin
      if (exp_gnt4.size() == 0) check("gnt4_unexpected", 64'(r4), 64'(0));
      else check("gnt4", 64'(r4), 64'(exp_gnt4.pop_front()));
    end
    if (mwr2 || mrd2) begin
      if (exp_cmd.size() == 0) check("cmd_unexpected", 64'({mwr2, mrd2}), 64'(0));
      else begin
        c = exp_cmd.pop_front();
        check("cmd_cycle", 64'(cyc), 64'(c.cyc));
        check("cmd_wr_rd", 64'({mwr2, mrd2}), 64'({c.wr, c.rd}));
        check("cmd_addr", 64'(maddr2), 64'(c.addr));
        check("cmd_wdata", 64'(mwdata2), 64'(c.wdata));
        check("cmd_wstrb", 64'(mwstrb2), 64'(c.wstrb));
      end
    end
    if (rv2 != 2'b00) begin
      if (exp_resp.size() == 0) check("resp_unexpected", 64'(rv2), 64'(0));
      else begin
        r = exp_resp.pop_front();
        check("resp_cycle", 64'(cyc), 64'(r.cyc));
        check("resp_valid", 64'(rv2), 64'(r.vld));
        check("resp_data", 64'(rdata2), 64'(r.data));
      end
    end
    if (rv4 != 4'b0000) check("resp4_unexpected", 64'(rv4), 64'(0));
  end

  // Presents one request on port p for one cycle; caller is #1 after a rising edge.
  task automatic issue2(input int p, input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [31:0] rd_exp, input bit want_resp);
    cmd_t  c;
    resp_t r;
    v2 = 2'b00;
    v2[p] = 1'b1;
    we2[p] = we;
    addr2[p*32 +: 32] = a;
    wdata2[p*32 +: 32] = d;
    wstrb2[p*4 +: 4] = s;
    exp_gnt2.push_back(2'(1 << p));
    c = '{cyc + 1, we, !we, a, d, s};
    exp_cmd.push_back(c);
    if (!we && want_resp) begin
      r = '{cyc + 3, 2'(1 << p), rd_exp};
      exp_resp.push_back(r);
    end
    @(posedge clk); #1;
    v2 = 2'b00;
  endtask

  initial begin
    cmd_t c;
    rst_n = 1'b1;
    v2 = '0; we2 = '0; addr2 = '0; wdata2 = '0; wstrb2 = '0;
    v4 = '0; we4 = '1; addr4 = '0; wdata4 = '0; wstrb4 = '0;
    #1 rst_n = 1'b0;

    // Reset state with both ports requesting
    v2 = 2'b11; we2 = 2'b11;
    addr2 = {32'h104, 32'h100}; wdata2 = {32'hB1, 32'hA0}; wstrb2 = {4'hC, 4'h3};
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 64'(r2), 64'(0));
    check("rst_m_wr", 64'(mwr2), 64'(0));
    check("rst_m_rd", 64'(mrd2), 64'(0));
    check("rst_m_addr", 64'(maddr2), 64'(0));
    check("rst_m_wdata", 64'(mwdata2), 64'(0));
    check("rst_m_wstrb", 64'(mwstrb2), 64'(0));
    check("rst_resp", 64'(rv2), 64'(0));

    // Contention from reset: grants alternate 0,1,0,1,0,1
    @(posedge clk); #2;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_gnt2.push_back((k % 2 == 0) ? 2'b01 : 2'b10);
      if (k % 2 == 0) c = '{cyc + 1 + k, 1'b1, 1'b0, 32'h100, 32'hA0, 4'h3};
      else            c = '{cyc + 1 + k, 1'b1, 1'b0, 32'h104, 32'hB1, 4'hC};
      exp_cmd.push_back(c);
    end
    repeat (6) @(posedge clk);
    #1 v2 = 2'b00;
    repeat (2) @(posedge clk); #1;

    // Single write on port 1, then bus fields hold while idle
    issue2(1, 1'b1, 32'h10, 32'hA5A5A5A5, 4'hF, 32'h0, 1'b0);
    repeat (2) @(posedge clk); #1;
    check("idle_m_wr", 64'(mwr2), 64'(0));
    check("idle_m_addr", 64'(maddr2), 64'(32'h10));
    check("idle_m_wdata", 64'(mwdata2), 64'(32'hA5A5A5A5));
    check("idle_m_wstrb", 64'(mwstrb2), 64'(4'hF));

    // Single read on port 0
    issue2(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b1);
    repeat (4) @(posedge clk); #1;

    // Back-to-back reads: port 0 then port 1
    issue2(0, 1'b0, 32'h24, 32'h0, 4'h0, 32'hCAFEBABE, 1'b1);
    issue2(1, 1'b0, 32'h30, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1);
    repeat (5) @(posedge clk); #1;

    // Lone continuous requester is granted every cycle
    issue2(1, 1'b1, 32'h40, 32'h11, 4'h1, 32'h0, 1'b0);
    issue2(1, 1'b1, 32'h44, 32'h22, 4'h2, 32'h0, 1'b0);
    issue2(1, 1'b1, 32'h48, 32'h33, 4'h4, 32'h0, 1'b0);
    issue2(1, 1'b1, 32'h4C, 32'h44, 4'h8, 32'h0, 1'b0);
    repeat (2) @(posedge clk); #1;

    // Reset lands while a read is in flight; its response must never appear
    issue2(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    v2 = 2'b11; we2 = 2'b11;
    #1;
    check("rst2_ready", 64'(r2), 64'(0));
    check("rst2_m_wr", 64'(mwr2), 64'(0));
    check("rst2_m_rd", 64'(mrd2), 64'(0));
    check("rst2_m_addr", 64'(maddr2), 64'(0));
    check("rst2_resp", 64'(rv2), 64'(0));
    repeat (2) @(posedge clk); #1;
    v2 = 2'b00;
    #1 rst_n = 1'b1;
    repeat (8) @(posedge clk); #1;

    // Pointer back at 0 after reset: simultaneous request goes to port 0
    v2 = 2'b11;
    addr2 = {32'h204, 32'h200}; wdata2 = {32'h2, 32'h1}; wstrb2 = {4'h2, 4'h1};
    exp_gnt2.push_back(2'b01);
    c = '{cyc + 1, 1'b1, 1'b0, 32'h200, 32'h1, 4'h1};
    exp_cmd.push_back(c);
    @(posedge clk); #1;
    v2 = 2'b00;
    repeat (2) @(posedge clk); #1;

    // 4-port pointer wrap: port3 alone, then ports 0 and 3
    v4 = 4'b1000;
    exp_gnt4.push_back(4'b1000);
    @(posedge clk); #1;
    v4 = 4'b1001;
    exp_gnt4.push_back(4'b0001);
    exp_gnt4.push_back(4'b1000);
    repeat (2) @(posedge clk); #1;

    // All four continuous: each once per four cycles
    v4 = 4'b1111;
    for (int k = 0; k < 8; k++) exp_gnt4.push_back(4'(1 << (k % 4)));
    repeat (8) @(posedge clk); #1;
    v4 = 4'b0000;

    repeat (6) @(posedge clk); #1;
    check("gnt2_left", 64'(exp_gnt2.size()), 64'(0));
    check("gnt4_left", 64'(exp_gnt4.size()), 64'(0));
    check("cmd_left", 64'(exp_cmd.size()), 64'(0));
    check("resp_left", 64'(exp_resp.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
